// File: rtl/rotary_freq_ctrl.sv
// rotary_freq_ctrl: rotary-encoder front end for the DDS function generator.
// Debounces Rot_A/Rot_B/Rot_C, decodes full quadrature detents and keeps a
// saturating frequency index. Address/FreqChng refresh on a periodic tick.
// Optional feature macro: ROT_ACCEL_EN (step acceleration on fast rotation).
//
// Quadrature FSM states (debounced {A,B}):
//   state  | meaning
//   Q_IDLE | at rest on 11, waiting for a detent to start
//   Q_CW1  | 01, first CW phase
//   Q_CW2  | 00, second CW phase
//   Q_CW3  | 10, third CW phase; return to 11 emits an up-event
//   Q_CCW1 | 10, first CCW phase
//   Q_CCW2 | 00, second CCW phase
//   Q_CCW3 | 01, third CCW phase; return to 11 emits a down-event
//   Q_HOLD | illegal two-bit jump seen, wait for 11 with no event
module rotary_freq_ctrl #(
  parameter int AW         = 11,
  parameter int MIN_VAL    = 0,
  parameter int MIN_VAL_LM = 800,
  parameter int MAX_VAL    = 1800,
  parameter int LIMIT_MODE = 4,
  parameter int DB_CYC     = 16,
  parameter int UPD_CYC    = 2400,
  parameter int STEP0      = 1,
  parameter int STEP1      = 10,
  parameter int STEP2      = 100,
  parameter int ACCEL_WIN  = 50000,
  parameter int ACCEL_MUL  = 4
) (
  input  logic          Fg_CLK,
  input  logic          RESET,
  input  logic          Rot_A,
  input  logic          Rot_B,
  input  logic          Rot_C,
  input  logic [2:0]    Mode,
  output logic [AW-1:0] Address,
  output logic          FreqChng,
  output logic [1:0]    StepSel
);

  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(DB_CYC + 1);
  localparam int TW  = $clog2(UPD_CYC);

  typedef enum logic [2:0] {
    Q_IDLE, Q_CW1, Q_CW2, Q_CW3, Q_CCW1, Q_CCW2, Q_CCW3, Q_HOLD
  } q_state_t;

  // bit order {C, A, B}; idle levels A=B=1, C=0
  logic [2:0]    s1, s2, db;
  logic [CW-1:0] db_cnt [3];
  logic          c_q;
  q_state_t      q_state;
  logic [1:0]    ab;
  logic          up_ev, dn_ev, c_rise, tick;
  logic [AW1-1:0] count, step, step_app, lo, sum;
  logic [TW-1:0]  upd_tmr;

  // two-flop synchroniser followed by a stable-for-DB_CYC debouncer
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      s1 <= 3'b011;
      s2 <= 3'b011;
      db <= 3'b011;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= {Rot_C, Rot_A, Rot_B};
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != db[i]) begin
          if (db_cnt[i] == CW'(DB_CYC - 1)) begin
            db[i]     <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign ab    = db[1:0];
  assign up_ev = (q_state == Q_CW3)  && (ab == 2'b11);
  assign dn_ev = (q_state == Q_CCW3) && (ab == 2'b11);

  // quadrature detent decoder
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      q_state <= Q_IDLE;
    end else begin
      case (q_state)
        Q_IDLE: case (ab)
          2'b01:   q_state <= Q_CW1;
          2'b10:   q_state <= Q_CCW1;
          2'b00:   q_state <= Q_HOLD;
          default: q_state <= Q_IDLE;
        endcase
        Q_CW1: case (ab)
          2'b00:   q_state <= Q_CW2;
          2'b11:   q_state <= Q_IDLE;
          2'b10:   q_state <= Q_HOLD;
          default: q_state <= Q_CW1;
        endcase
        Q_CW2: case (ab)
          2'b10:   q_state <= Q_CW3;
          2'b01:   q_state <= Q_CW1;
          2'b11:   q_state <= Q_IDLE;
          default: q_state <= Q_CW2;
        endcase
        Q_CW3: case (ab)
          2'b11:   q_state <= Q_IDLE;
          2'b00:   q_state <= Q_CW2;
          2'b01:   q_state <= Q_HOLD;
          default: q_state <= Q_CW3;
        endcase
        Q_CCW1: case (ab)
          2'b00:   q_state <= Q_CCW2;
          2'b11:   q_state <= Q_IDLE;
          2'b01:   q_state <= Q_HOLD;
          default: q_state <= Q_CCW1;
        endcase
        Q_CCW2: case (ab)
          2'b01:   q_state <= Q_CCW3;
          2'b10:   q_state <= Q_CCW1;
          2'b11:   q_state <= Q_IDLE;
          default: q_state <= Q_CCW2;
        endcase
        Q_CCW3: case (ab)
          2'b11:   q_state <= Q_IDLE;
          2'b00:   q_state <= Q_CCW2;
          2'b10:   q_state <= Q_HOLD;
          default: q_state <= Q_CCW3;
        endcase
        default: q_state <= (ab == 2'b11) ? Q_IDLE : Q_HOLD;
      endcase
    end
  end

  assign c_rise = db[2] & ~c_q;

  // push-button cycles the step selector 0 > 1 > 2 > 0
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      c_q     <= 1'b0;
      StepSel <= 2'd0;
    end else begin
      c_q <= db[2];
      if (c_rise) StepSel <= (StepSel == 2'd2) ? 2'd0 : StepSel + 2'd1;
    end
  end

  // step lookup for the active selector
  always_comb begin
    step = AW1'(STEP2);
    case (StepSel)
      2'd0:    step = AW1'(STEP0);
      2'd1:    step = AW1'(STEP1);
      default: step = AW1'(STEP2);
    endcase
  end

`ifdef ROT_ACCEL_EN
  localparam int ATW = $clog2(ACCEL_WIN + 1);
  logic [ATW-1:0] accel_tmr;
  logic           accel_arm;

  // time since the previous detent; arm stays low until the first event
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      accel_tmr <= '0;
      accel_arm <= 1'b0;
    end else if (up_ev || dn_ev) begin
      accel_tmr <= '0;
      accel_arm <= 1'b1;
    end else if (accel_tmr != ATW'(ACCEL_WIN)) begin
      accel_tmr <= accel_tmr + 1'b1;
    end
  end

  assign step_app = (accel_arm && (accel_tmr < ATW'(ACCEL_WIN)))
                  ? step * AW1'(ACCEL_MUL) : step;
`else
  assign step_app = step;
`endif

  assign lo  = (Mode == 3'(LIMIT_MODE)) ? AW1'(MIN_VAL_LM) : AW1'(MIN_VAL);
  assign sum = count + step_app;

  // saturating frequency index; the limit-mode clamp wins over a same-cycle event
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      count <= '0;
    end else if ((Mode == 3'(LIMIT_MODE)) && (count < AW1'(MIN_VAL_LM))) begin
      count <= AW1'(MIN_VAL_LM);
    end else if (up_ev) begin
      count <= (sum > AW1'(MAX_VAL)) ? AW1'(MAX_VAL) : sum;
    end else if (dn_ev) begin
      count <= (count < lo + step_app) ? lo : count - step_app;
    end
  end

  assign tick = (upd_tmr == TW'(UPD_CYC - 1));

  // periodic refresh of Address with a one-cycle change strobe
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      upd_tmr  <= '0;
      Address  <= '0;
      FreqChng <= 1'b0;
    end else begin
      upd_tmr  <= tick ? '0 : upd_tmr + 1'b1;
      FreqChng <= 1'b0;
      if (tick) begin
        Address  <= count[AW-1:0];
        FreqChng <= (Address != count[AW-1:0]);
      end
    end
  end

endmodule
